// File: rtl/bta_pkg.sv
// bta_pkg
// Shared definitions for the tree-adder operand loader: loader state
// encoding, the fixed operand count per addition set, counter widths and
// the default operand width / adder latency.
package bta_pkg;

   localparam int K       = 8;   // operands per addition set
   localparam int CNT_W   = 3;   // slot counter width, log2(K)
   localparam int WCNT_W  = 4;   // latency counter width, covers LAT up to 15
   localparam int M_DEF   = 16;  // default operand width
   localparam int LAT_DEF = 2;   // default tree-adder latency in cycles

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESULT  = 2'd3
   } bta_state_e;

endpackage

// File: rtl/bta_operand_bank.sv
// bta_operand_bank
// K x M operand register file. One slot is written per cycle when i_we is
// high, selected by i_waddr. All slots are readable in parallel so the tree
// adder sees the whole set at once. Synchronous active-high reset clears
// every slot.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous reset, active high
//   i_we     write enable
//   i_waddr  slot index to write
//   i_wdata  operand value
//   o_ops    all slots, o_ops[0] is slot 0
module bta_operand_bank
   import bta_pkg::*;
#(
   parameter int M = M_DEF
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_we,
   input  logic [CNT_W-1:0]      i_waddr,
   input  logic [M-1:0]          i_wdata,
   output logic [K-1:0][M-1:0]   o_ops
);

   logic [K-1:0]        w_we_slot;
   logic [K-1:0][M-1:0] r_ops;

   always_comb begin
      w_we_slot = '0;
      for (int k = 0; k < K; k++) begin
         w_we_slot[k] = i_we && (i_waddr == CNT_W'(k));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ops <= '0;
      end else begin
         for (int k = 0; k < K; k++) begin
            if (w_we_slot[k]) begin
               r_ops[k] <= i_wdata;
            end
         end
      end
   end

   assign o_ops = r_ops;

endmodule

// File: rtl/bta_operand_loader.sv
// bta_operand_loader
// Collects K=8 operands (plus a carry-in taken with operand 0) over a
// valid/ready stream, launches a fixed-latency tree adder with a one-cycle
// pulse, waits LAT cycles, captures the sum/carry and holds them until the
// downstream consumer accepts. No new operands are taken while a result is
// pending.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand stream handshake
//   in_data, in_cin        operand value, carry-in (used with slot 0 only)
//   op_a..op_h, op_c0      operands 0..7 and carry-in to the tree adder
//   add_start              one-cycle launch pulse to the tree adder
//   add_sum, add_carry     tree adder result
//   res_valid/res_ready    result handshake
//   res_sum, res_carry     captured result
//   busy                   high whenever not collecting operands
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_COLLECT | accepting operands into slots 0..7
// ST_LAUNCH  | operand set complete, add_start pulsed
// ST_WAIT    | counting adder latency, capture at wcnt==LAT
// ST_RESULT  | result held until res_valid & res_ready
module bta_operand_loader
   import bta_pkg::*;
#(
   parameter int M   = M_DEF,
   parameter int LAT = LAT_DEF
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M-1:0]   in_data,
   input  logic           in_cin,
   output logic [M-1:0]   op_a,
   output logic [M-1:0]   op_b,
   output logic [M-1:0]   op_c,
   output logic [M-1:0]   op_d,
   output logic [M-1:0]   op_e,
   output logic [M-1:0]   op_f,
   output logic [M-1:0]   op_g,
   output logic [M-1:0]   op_h,
   output logic           op_c0,
   output logic           add_start,
   input  logic [M+4:0]   add_sum,
   input  logic           add_carry,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [M+4:0]   res_sum,
   output logic           res_carry,
   output logic           busy
);

   localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(K - 1);
   localparam logic [WCNT_W-1:0] LAT_W     = WCNT_W'(LAT);

   bta_state_e          r_state;
   bta_state_e          w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [WCNT_W-1:0]   r_wcnt;
   logic                r_c0;
   logic [M+4:0]        r_sum;
   logic                r_carry;

   logic                w_in_ready;
   logic                w_add_start;
   logic                w_res_valid;
   logic                w_busy;
   logic                w_accept;
   logic [K-1:0][M-1:0] w_ops;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs decode r_state only, so in_ready never sees res_ready.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_add_start = 1'b0;
      w_res_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_COLLECT: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
            if (in_valid && (r_cnt == LAST_SLOT)) begin
               w_state_nxt = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            w_add_start = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wcnt == LAT_W) begin
               w_state_nxt = ST_RESULT;
            end
         end
         ST_RESULT: begin
            w_res_valid = 1'b1;
            if (res_ready) begin
               w_state_nxt = ST_COLLECT;
            end
         end
         default: begin
            w_state_nxt = ST_COLLECT;
         end
      endcase
   end

   assign w_accept = w_in_ready && in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_wcnt  <= '0;
         r_c0    <= 1'b0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         if (w_accept) begin
            // slot 7 wraps the 3-bit counter back to 0 for the next set
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == '0) begin
               r_c0 <= in_cin;
            end
         end
         if (r_state == ST_LAUNCH) begin
            r_wcnt <= WCNT_W'(1);
         end else if (r_state == ST_WAIT) begin
            if (r_wcnt == LAT_W) begin
               r_wcnt  <= '0;
               r_sum   <= add_sum;
               r_carry <= add_carry;
            end else begin
               r_wcnt <= r_wcnt + WCNT_W'(1);
            end
         end
      end
   end

   bta_operand_bank #(
      .M (M)
   ) u_bank (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (w_accept),
      .i_waddr (r_cnt),
      .i_wdata (in_data),
      .o_ops   (w_ops)
   );

   assign op_a      = w_ops[0];
   assign op_b      = w_ops[1];
   assign op_c      = w_ops[2];
   assign op_d      = w_ops[3];
   assign op_e      = w_ops[4];
   assign op_f      = w_ops[5];
   assign op_g      = w_ops[6];
   assign op_h      = w_ops[7];
   assign op_c0     = r_c0;
   assign in_ready  = w_in_ready;
   assign add_start = w_add_start;
   assign res_valid = w_res_valid;
   assign busy      = w_busy;
   assign res_sum   = r_sum;
   assign res_carry = r_carry;

endmodule

// File: tb/tb_bta_operand_loader.sv
// Bench for bta_operand_loader at M=16, LAT=2 with a two-stage tree-adder
// model. A transaction-level model tracks accepted operands, the expected
// result and its arrival time; a negedge process compares every cycle.
module tb_bta_operand_loader;
   localparam int M   = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [M-1:0]  in_data;
   logic          in_cin;
   logic [M-1:0]  op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
   logic          op_c0;
   logic          add_start;
   logic [M+4:0]  add_sum;
   logic          add_carry;
   logic          res_valid;
   logic          res_ready;
   logic [M+4:0]  res_sum;
   logic          res_carry;
   logic          busy;

   always #5 clk = ~clk;

   bta_operand_loader #(.M(M), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_cin(in_cin),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h),
      .op_c0(op_c0), .add_start(add_start), .add_sum(add_sum),
      .add_carry(add_carry), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_carry(res_carry), .busy(busy)
   );

   // Tree adder: sum latched on the add_start edge, one more register stage.
   logic [M+5:0] p0 = '0, p1 = '0;
   always @(posedge clk) begin
      if (add_start)
         p0 <= (M+6)'(op_a) + (M+6)'(op_b) + (M+6)'(op_c) + (M+6)'(op_d)
             + (M+6)'(op_e) + (M+6)'(op_f) + (M+6)'(op_g) + (M+6)'(op_h)
             + (M+6)'(op_c0);
      p1 <= p0;
   end
   assign add_sum   = p1[M+4:0];
   assign add_carry = p1[M+5];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level model
   logic [M-1:0] m_ops [8];
   logic         m_c0;
   int           m_n;
   bit           m_init = 0;
   bit           m_collect;
   bit           m_resv;
   bit           m_astart;
   int           m_cd;
   logic [M+4:0] m_sum;
   logic         m_carry;
   logic [M+5:0] m_tot;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_init = 1; m_n = 0; m_collect = 1; m_resv = 0; m_astart = 0; m_cd = 0;
         for (int i = 0; i < 8; i++) m_ops[i] = '0;
         m_c0 = 0; m_sum = '0; m_carry = 0;
      end else if (m_init) begin
         m_astart = 0;
         if (m_collect) begin
            if (in_valid) begin
               m_ops[m_n] = in_data;
               if (m_n == 0) m_c0 = in_cin;
               m_n++;
               last_acc_cyc = cyc;
               if (m_n == 8) begin
                  m_n = 0; m_collect = 0; m_astart = 1; m_cd = LAT + 1;
                  m_tot = (M+6)'(m_c0);
                  for (int i = 0; i < 8; i++) m_tot += (M+6)'(m_ops[i]);
               end
            end
         end else if (m_resv) begin
            if (res_ready) begin m_resv = 0; m_collect = 1; end
         end else begin
            m_cd--;
            if (m_cd == 0) begin
               m_resv = 1; m_sum = m_tot[M+4:0]; m_carry = m_tot[M+5];
            end
         end
      end
   end

   // Event counters and the per-cycle compare.
   int           n_astart = 0;
   int           n_acc = 0;
   int           n_pulse = 0;
   logic [31:0]  pulse_sum [2];
   logic         prev_rv = 0;

   initial forever begin
      @(negedge clk);
      if (m_init) begin
         chk("in_ready", in_ready, m_collect);
         chk("busy", busy, !m_collect);
         chk("res_valid", res_valid, m_resv);
         chk("add_start", add_start, m_astart);
         if (m_resv) begin
            chk("res_sum", res_sum, m_sum);
            chk("res_carry", res_carry, m_carry);
         end
         if (!m_collect) begin
            chk("op_a", op_a, m_ops[0]); chk("op_b", op_b, m_ops[1]);
            chk("op_c", op_c, m_ops[2]); chk("op_d", op_d, m_ops[3]);
            chk("op_e", op_e, m_ops[4]); chk("op_f", op_f, m_ops[5]);
            chk("op_g", op_g, m_ops[6]); chk("op_h", op_h, m_ops[7]);
            chk("op_c0", op_c0, m_c0);
         end
      end
      if (add_start === 1'b1) n_astart++;
      if (in_valid && in_ready === 1'b1) n_acc++;
      if (res_valid === 1'b1 && !prev_rv) begin
         if (n_pulse < 2) pulse_sum[n_pulse] = 32'(res_sum);
         n_pulse++;
      end
      prev_rv = (res_valid === 1'b1);
   end

   task automatic send_op(input logic [M-1:0] d, input logic c);
      int n;
      n = 0;
      in_valid = 1; in_data = d; in_cin = c;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
         if (n > 50) begin
            errors++; checks++;
            $display("FAIL send_op: in_ready stuck at %b, expected 1 within 50 cycles", in_ready);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_rst();
      rst = 1; @(posedge clk); #1; rst = 0;
   endtask

   task automatic wait_result(output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (res_valid !== 1'b1) begin
         errors++; checks++;
         $display("FAIL wait_result: res_valid=%b, expected 1 within 100 cycles", res_valid);
      end
      lat = cyc - last_acc_cyc;
   endtask

   task automatic consume();
      res_ready = 1; @(posedge clk); #1; res_ready = 0;
   endtask

   initial begin
      int lat;
      rst = 1; in_valid = 0; in_data = '0; in_cin = 0; res_ready = 0;
      idle(3);
      rst = 0;
      @(negedge clk);
      chk("rst in_ready", in_ready, 1);
      chk("rst res_valid", res_valid, 0);
      chk("rst res_sum", res_sum, 0);
      chk("rst op_a", op_a, 0);
      chk("rst op_h", op_h, 0);
      chk("rst busy", busy, 0);
      idle(1);

      // 1..8 back to back, then hold the result for 5 cycles
      n_astart = 0;
      for (int i = 0; i < 8; i++) send_op(M'(i + 1), 1'b0);
      wait_result(lat);
      chk("t1 latency", lat, 3);
      repeat (5) @(negedge clk);
      chk("t1 sum", res_sum, 36);
      chk("t1 carry", res_carry, 0);
      chk("t1 hold in_ready", in_ready, 0);
      chk("t1 hold res_valid", res_valid, 1);
      consume();
      @(negedge clk);
      chk("t1 in_ready after accept", in_ready, 1);
      chk("t1 add_start count", n_astart, 1);
      idle(1);

      // all ones with carry-in
      for (int i = 0; i < 8; i++) send_op(16'hFFFF, i == 0);
      wait_result(lat);
      chk("t2 sum", res_sum, 32'h7FFF9);
      chk("t2 carry", res_carry, 0);
      consume();

      // toggling valid; cin on non-zero slots must be ignored
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         send_op(M'(100 + 13 * i), i != 0);
         idle(1);
      end
      wait_result(lat);
      chk("t3 accepts", n_acc, 8);
      chk("t3 sum", res_sum, 1164);
      chk("t3 op_c0", op_c0, 0);
      consume();

      // reset mid-set discards the partial set
      n_astart = 0;
      for (int i = 0; i < 5; i++) send_op(M'(20 + i), 1'b1);
      pulse_rst();
      for (int i = 10; i < 18; i++) send_op(M'(i), 1'b0);
      chk("t4 no early add_start", n_astart, 0);
      wait_result(lat);
      chk("t4 sum", res_sum, 108);
      chk("t4 add_start count", n_astart, 1);
      consume();

      // reset mid-wait discards the pending result
      for (int i = 0; i < 8; i++) send_op(M'(i + 50), 1'b1);
      idle(2);
      pulse_rst();
      repeat (6) @(negedge clk);
      chk("t5 res_valid", res_valid, 0);
      chk("t5 in_ready", in_ready, 1);
      idle(1);

      // two sets back to back, res_ready tied high
      res_ready = 1;
      n_pulse = 0;
      for (int i = 0; i < 8; i++) send_op(M'(1000 + i), i == 0);
      for (int i = 0; i < 8; i++) send_op(M'(7 * i + 3), 1'b0);
      repeat (10) @(negedge clk);
      chk("t6 pulses", n_pulse, 2);
      chk("t6 sum a", pulse_sum[0], 8029);
      chk("t6 sum b", pulse_sum[1], 220);
      chk("t6 op_c0", op_c0, 0);
      res_ready = 0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bta_operand_loader.md
BTA_OPERAND_LOADER -- requirements
Module: bta_operand_loader

Interface
REQ-001 Parameter M, default 16: operand width in bits.
REQ-002 Parameter K, fixed 8: operands per addition set; not overridable.
REQ-003 Parameter LAT, default 2: tree-adder latency in clk cycles; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 in_valid  in  1  upstream operand valid.
REQ-007 in_ready  out  1  loader accepts operand this cycle.
REQ-008 in_data  in  M  operand value.
REQ-009 in_cin  in  1  carry-in; sampled only with operand 0 of a set.
REQ-010 op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h  out  M each  operands 0..7 to the tree adder.
REQ-011 op_c0  out  1  carry-in to the tree adder.
REQ-012 add_start  out  1  one-cycle launch pulse to the tree adder.
REQ-013 add_sum  in  M+5  adder sum, bits [M+4:0].
REQ-014 add_carry  in  1  adder carry-out.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  downstream accepts result.
REQ-017 res_sum  out  M+5  captured sum.
REQ-018 res_carry  out  1  captured carry.
REQ-019 busy  out  1  high in every state except COLLECT.

Function
REQ-020 FSM SHALL have exactly four states: COLLECT, LAUNCH, WAIT, RESULT.
REQ-021 COLLECT: in_ready=1; each in_valid&in_ready edge SHALL store in_data into slot cnt, where slot 0 maps to op_a and slot 7 to op_h, then increment cnt (3 bits).
REQ-022 The handshake edge storing slot 0 SHALL also store in_cin into op_c0.
REQ-023 The accept edge for slot 7 SHALL move COLLECT to LAUNCH and wrap cnt to 0.
REQ-024 in_valid low SHALL stall collection with no state change; gaps of any length are legal.
REQ-025 LAUNCH: add_start=1 for exactly one cycle; next state WAIT with wcnt=1.
REQ-026 WAIT: wcnt SHALL increment each cycle; on the edge ending the cycle where wcnt==LAT, add_sum and add_carry SHALL be captured into res_sum and res_carry and the state SHALL become RESULT.
REQ-027 Latency: res_valid SHALL first be high LAT+1 edges after the slot-7 accept edge (3 cycles at LAT=2).
REQ-028 op_a..op_h and op_c0 SHALL hold stable from LAUNCH through the end of WAIT, and until the slot-0 accept of the next set.
REQ-029 RESULT: res_valid=1 with res_sum and res_carry held stable until a res_valid&res_ready edge, then next state COLLECT.
REQ-030 in_ready SHALL be 0 in LAUNCH, WAIT and RESULT; the loader SHALL accept no operand while a result is pending.
REQ-031 in_ready SHALL NOT depend combinationally on res_ready; there is no same-cycle result-to-operand bypass.
REQ-032 add_start, in_ready, res_valid and busy SHALL be registered-state decodes with no combinational path from any input.

Reset
REQ-033 While rst is high, the next edge SHALL force: state COLLECT, cnt=0, wcnt=0, all op_* =0, op_c0=0, add_start=0, res_valid=0, res_sum=0, res_carry=0.
REQ-034 rst SHALL take priority over any simultaneous handshake.
REQ-035 rst asserted mid-set or mid-WAIT SHALL discard the partial set or pending result; the next accepted operand SHALL be slot 0.
REQ-036 From the first edge after rst goes low, in_ready SHALL be 1.

Structure
REQ-037 Shared package bta_pkg SHALL hold the state enum, K, and the default values of M and LAT.
REQ-038 The operand register file (8xM with write-enable decode) SHALL be the single sub-module bta_operand_bank; the FSM and counters stay in the top module.

Verification
REQ-039 The bench SHALL instantiate bta_operand_loader with an LAT=2 tree-adder behavioural model driving add_sum and add_carry.
REQ-040 Operands 1..8 back-to-back, cin=0: add_start fires once; res_sum=36 and res_carry=0, with res_valid 3 cycles after the 8th accept.
REQ-041 All operands 16'hFFFF, cin=1: res_sum=0x7FFF9 and res_carry=0.
REQ-042 in_valid toggling 1/0 every cycle across 8 operands: exactly 8 accepts; cnt never skips a slot; the result matches the model.
REQ-043 res_ready held low 5 cycles in RESULT: res_valid and res_sum stay stable and in_ready=0; res_ready=1 accepts on one edge, and in_ready=1 on the next cycle.
REQ-044 rst pulsed after 5 accepted operands, then operands 10..17 sent: res_sum=108; no add_start occurs before the 8th post-reset accept.
REQ-045 Two sets sent back-to-back with res_ready tied high: each set yields exactly one res_valid pulse with the correct sum; the second set's op_c0 equals its own slot-0 cin.
